// File: rtl/rbm_pkg.sv
// Shared state encoding, layer selects and sizing helper
// for the RBM inference sequencer.
package rbm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HID_ACC,
        S_HID_FIRE,
        S_CLS_ACC,
        S_CLS_FIRE,
        S_ARGMAX,
        S_DONE
    } state_t;

    localparam logic HID = 1'b0;
    localparam logic CLS = 1'b1;

    // Sum of N weights plus a bias, with headroom for the sign.
    function automatic int acc_width(input int w, input int n);
        return w + $clog2(n + 2);
    endfunction

endpackage

// File: rtl/rbm_neuron_acc.sv
// Gated signed accumulator with bias add and strict threshold
// compare; shared by the hidden and classifier layers.
module rbm_neuron_acc #(
    parameter int W_WIDTH = 12,
    parameter int ACC_W   = 22
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               add_en,
    input  logic               gate,
    input  logic [W_WIDTH-1:0] w_data,
    input  logic [W_WIDTH-1:0] rand_in,
    output logic               fire
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] thresh;

    always_comb begin
        addend = '0;
        if (add_en && gate) begin
            addend = {{(ACC_W-W_WIDTH){w_data[W_WIDTH-1]}}, w_data};
        end
        thresh   = {{(ACC_W-W_WIDTH){rand_in[W_WIDTH-1]}}, rand_in};
        acc_next = acc + addend;
        fire     = acc_next > thresh;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/rbm_infer_ctrl.sv
// Two-layer RBM inference sequencer: iterates visible->hidden->class,
// counts class spikes with saturation and reports the arg-max class.
module rbm_infer_ctrl
    import rbm_pkg::*;
#(
    parameter int N_VIS     = 784,
    parameter int N_HID     = 441,
    parameter int N_CLS     = 10,
    parameter int N_ITER    = 30,
    parameter int W_WIDTH   = 12,
    parameter int CNT_WIDTH = 8,
    localparam int MAX_IN   = (N_VIS > N_HID) ? N_VIS : N_HID,
    localparam int MAX_NR   = (N_HID > N_CLS) ? N_HID : N_CLS,
    localparam int ROW_W    = $clog2(MAX_IN),
    localparam int COL_W    = $clog2(MAX_NR),
    localparam int VIS_W    = $clog2(N_VIS),
    localparam int CLS_W    = (N_CLS > 1) ? $clog2(N_CLS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 w_rd_en,
    output logic                 w_layer,
    output logic                 w_bias,
    output logic [ROW_W-1:0]     w_row,
    output logic [COL_W-1:0]     w_col,
    input  logic [W_WIDTH-1:0]   w_data,
    output logic [VIS_W-1:0]     vis_addr,
    input  logic                 vis_data,
    input  logic [W_WIDTH-1:0]   rand_in,
    output logic                 rand_req,
    input  logic [CLS_W-1:0]     cnt_sel,
    output logic [CNT_WIDTH-1:0] cnt_out,
    output logic [CLS_W-1:0]     class_out
);

    localparam int IDX_W  = $clog2(MAX_IN + 1);
    localparam int ITER_W = $clog2(N_ITER + 1);
    localparam int ACC_W  = acc_width(W_WIDTH, MAX_IN);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t state, state_nxt;

    logic [IDX_W-1:0]     idx;
    logic [COL_W-1:0]     col;
    logic [ITER_W-1:0]    iter;
    logic [CLS_W-1:0]     am_idx;
    logic [N_HID-1:0]     hid_bits;
    logic [CNT_WIDTH-1:0] cnt [N_CLS];
    logic [CNT_WIDTH-1:0] best_val;
    logic [CLS_W-1:0]     class_q;

    logic valid_q, bias_q, layer_q, hid_bit_q;
    logic acc_st, fire_st, last_in, last_col, last_iter, last_cls;
    logic hid_pick, in_bit, fire_bit;
    logic [CNT_WIDTH-1:0] am_val;

    always_comb begin
        acc_st    = (state == S_HID_ACC) || (state == S_CLS_ACC);
        fire_st   = (state == S_HID_FIRE) || (state == S_CLS_FIRE);
        last_in   = (state == S_CLS_ACC) ? (idx == IDX_W'(N_HID))
                                         : (idx == IDX_W'(N_VIS));
        last_col  = (state == S_CLS_FIRE) ? (col == COL_W'(N_CLS - 1))
                                          : (col == COL_W'(N_HID - 1));
        last_iter = iter == ITER_W'(N_ITER - 1);
        last_cls  = am_idx == CLS_W'(N_CLS - 1);
        in_bit    = bias_q | (layer_q ? hid_bit_q : vis_data);
        hid_pick  = 1'b0;
        for (int i = 0; i < N_HID; i++) begin
            if (idx == IDX_W'(i)) hid_pick = hid_bits[i];
        end
        am_val  = '0;
        cnt_out = '0;
        for (int c = 0; c < N_CLS; c++) begin
            if (am_idx == CLS_W'(c)) am_val = cnt[c];
            if (cnt_sel == CLS_W'(c)) cnt_out = cnt[c];
        end
    end

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = state == S_DONE;
    assign w_rd_en   = acc_st;
    assign w_layer   = (state == S_CLS_ACC) ? CLS : HID;
    assign w_bias    = acc_st && last_in;
    assign w_row     = idx[ROW_W-1:0];
    assign w_col     = col;
    assign vis_addr  = idx[VIS_W-1:0];
    assign rand_req  = fire_st;
    assign class_out = class_q;

    rbm_neuron_acc #(
        .W_WIDTH (W_WIDTH),
        .ACC_W   (ACC_W)
    ) u_acc (
        .clock   (clock),
        .reset   (reset),
        .clear   (fire_st),
        .add_en  (valid_q),
        .gate    (in_bit),
        .w_data  (w_data),
        .rand_in (rand_in),
        .fire    (fire_bit)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (start) state_nxt = S_HID_ACC;
            S_HID_ACC:  if (last_in) state_nxt = S_HID_FIRE;
            S_HID_FIRE: state_nxt = last_col ? S_CLS_ACC : S_HID_ACC;
            S_CLS_ACC:  if (last_in) state_nxt = S_CLS_FIRE;
            S_CLS_FIRE: begin
                if (!last_col)     state_nxt = S_CLS_ACC;
                else if (last_iter) state_nxt = S_ARGMAX;
                else               state_nxt = S_HID_ACC;
            end
            S_ARGMAX:   if (last_cls) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx       <= '0;
            col       <= '0;
            iter      <= '0;
            am_idx    <= '0;
            hid_bits  <= '0;
            best_val  <= '0;
            class_q   <= '0;
            valid_q   <= 1'b0;
            bias_q    <= 1'b0;
            layer_q   <= 1'b0;
            hid_bit_q <= 1'b0;
            for (int c = 0; c < N_CLS; c++) cnt[c] <= '0;
        end else begin
            // Read data returns one cycle later; keep its gating aligned.
            valid_q   <= acc_st;
            bias_q    <= acc_st && last_in;
            layer_q   <= state == S_CLS_ACC;
            hid_bit_q <= hid_pick;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        col     <= '0;
                        iter    <= '0;
                        class_q <= '0;
                        for (int c = 0; c < N_CLS; c++) cnt[c] <= '0;
                    end
                end
                S_HID_ACC, S_CLS_ACC: begin
                    idx <= last_in ? '0 : idx + IDX_W'(1);
                end
                S_HID_FIRE: begin
                    for (int h = 0; h < N_HID; h++) begin
                        if (col == COL_W'(h)) hid_bits[h] <= fire_bit;
                    end
                    col <= last_col ? '0 : col + COL_W'(1);
                end
                S_CLS_FIRE: begin
                    for (int c = 0; c < N_CLS; c++) begin
                        if (col == COL_W'(c) && fire_bit && cnt[c] != CNT_MAX)
                            cnt[c] <= cnt[c] + CNT_WIDTH'(1);
                    end
                    col <= last_col ? '0 : col + COL_W'(1);
                    if (last_col) begin
                        iter   <= iter + ITER_W'(1);
                        am_idx <= '0;
                    end
                end
                S_ARGMAX: begin
                    // Strict compare so ties keep the lowest class index.
                    if (am_idx == '0 || am_val > best_val) begin
                        best_val <= am_val;
                        class_q  <= am_idx;
                    end
                    am_idx <= am_idx + CLS_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rbm_infer_ctrl.sv
// Randomized and directed bench for rbm_infer_ctrl with a
// sum-of-products reference model and per-cycle control checks.
module tb_rbm_infer_ctrl;

    localparam int NV = 4;
    localparam int NH = 3;
    localparam int NC = 2;
    localparam int NI = 2;
    localparam int WW = 8;
    localparam int CW = 8;
    localparam int L = NH * (NV + 2) + NC * (NH + 2);
    localparam int DONE_CYC = NI * L + NC + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    always #5 clock = ~clock;

    logic busy, done, w_rd_en, w_layer, w_bias, vis_data, rand_req;
    logic [1:0] w_row, w_col, vis_addr;
    logic [WW-1:0] w_data, rand_in;
    logic [0:0] cnt_sel = 1'b0;
    logic [CW-1:0] cnt_out;
    logic [0:0] class_out;

    logic busy2, done2, w_rd_en2, w_layer2, w_bias2, vis_data2, rand_req2;
    logic [1:0] w_row2, w_col2, vis_addr2;
    logic [WW-1:0] w_data2;
    logic [WW-1:0] rand_in2 = '0;
    logic [0:0] cnt_sel2 = 1'b0;
    logic [0:0] cnt_out2;
    logic [0:0] class_out2;

    int hw [NH][NV];
    int hb [NH];
    int cw [NC][NH];
    int cb [NC];
    bit img [NV];
    int rseq [64];
    int rp = 0;
    int exp_cnt [NC];
    int exp_cls;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int start_edge = 0;
    int rq_cnt = 0;
    bit mon_on = 1'b0;

    rbm_infer_ctrl #(
        .N_VIS(NV), .N_HID(NH), .N_CLS(NC), .N_ITER(NI),
        .W_WIDTH(WW), .CNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy),
        .done(done), .w_rd_en(w_rd_en), .w_layer(w_layer),
        .w_bias(w_bias), .w_row(w_row), .w_col(w_col),
        .w_data(w_data), .vis_addr(vis_addr), .vis_data(vis_data),
        .rand_in(rand_in), .rand_req(rand_req), .cnt_sel(cnt_sel),
        .cnt_out(cnt_out), .class_out(class_out)
    );

    rbm_infer_ctrl #(
        .N_VIS(NV), .N_HID(NH), .N_CLS(NC), .N_ITER(3),
        .W_WIDTH(WW), .CNT_WIDTH(1)
    ) dut_sat (
        .clock(clock), .reset(reset), .start(start2), .busy(busy2),
        .done(done2), .w_rd_en(w_rd_en2), .w_layer(w_layer2),
        .w_bias(w_bias2), .w_row(w_row2), .w_col(w_col2),
        .w_data(w_data2), .vis_addr(vis_addr2), .vis_data(vis_data2),
        .rand_in(rand_in2), .rand_req(rand_req2), .cnt_sel(cnt_sel2),
        .cnt_out(cnt_out2), .class_out(class_out2)
    );

    function automatic logic [WW-1:0] rd_word(logic lay, logic b, int r, int c);
        int v;
        v = 0;
        if (!lay) begin
            if (c < NH) v = b ? hb[c] : ((r < NV) ? hw[c][r] : 0);
        end else begin
            if (c < NC) v = b ? cb[c] : ((r < NH) ? cw[c][r] : 0);
        end
        return WW'(v);
    endfunction

    always @(posedge clock) begin
        edge_n <= edge_n + 1;
        if (w_rd_en) w_data <= rd_word(w_layer, w_bias, int'(w_row), int'(w_col));
        if (w_rd_en2) w_data2 <= rd_word(w_layer2, w_bias2, int'(w_row2), int'(w_col2));
        vis_data  <= img[vis_addr];
        vis_data2 <= img[vis_addr2];
        if (reset) rp <= 0;
        else if (rand_req) rp <= rp + 1;
    end

    assign rand_in = WW'(rseq[rp]);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void model_run(input int cmax, input int iters);
        bit hid [NH];
        int k, s;
        k = 0;
        for (int c = 0; c < NC; c++) exp_cnt[c] = 0;
        for (int it = 0; it < iters; it++) begin
            for (int h = 0; h < NH; h++) begin
                s = hb[h];
                for (int r = 0; r < NV; r++) if (img[r]) s += hw[h][r];
                hid[h] = s > rseq[k];
                k++;
            end
            for (int c = 0; c < NC; c++) begin
                s = cb[c];
                for (int r = 0; r < NH; r++) if (hid[r]) s += cw[c][r];
                if (s > rseq[k] && exp_cnt[c] < cmax) exp_cnt[c]++;
                k++;
            end
        end
        exp_cls = 0;
        for (int c = 1; c < NC; c++) if (exp_cnt[c] > exp_cnt[exp_cls]) exp_cls = c;
    endfunction

    // Expected control outputs derived from the cycle position alone.
    function automatic logic [11:0] exp_vec(int cyc);
        logic bz, dn, rd, lay, bs, rq;
        logic [1:0] col, row, va;
        int t, p, n;
        bz = cyc >= 1 && cyc < DONE_CYC;
        dn = cyc == DONE_CYC;
        rd = 0; lay = 0; bs = 0; rq = 0; col = 0; row = 0; va = 0;
        if (cyc >= 1 && cyc <= NI * L) begin
            t = (cyc - 1) % L;
            if (t < NH * (NV + 2)) begin
                n = NV; lay = 0; col = 2'(t / (NV + 2)); p = t % (NV + 2);
            end else begin
                t = t - NH * (NV + 2);
                n = NH; lay = 1; col = 2'(t / (NH + 2)); p = t % (NH + 2);
            end
            rd = p <= n;
            bs = p == n;
            rq = p == n + 1;
            if (p < n) begin
                row = 2'(p);
                if (!lay) va = 2'(p);
            end
            if (!rd) begin lay = 0; col = 0; end
        end
        return {bz, dn, rd, lay, bs, rq, col, row, va};
    endfunction

    logic [11:0] act_vec;
    always_comb begin
        act_vec = {busy, done, w_rd_en, w_rd_en & w_layer, w_bias, rand_req,
                   w_rd_en ? w_col : 2'd0,
                   (w_rd_en & ~w_bias) ? w_row : 2'd0,
                   (w_rd_en & ~w_bias & ~w_layer) ? vis_addr : 2'd0};
    end

    always @(negedge clock) begin
        if (mon_on) begin
            if (rand_req) rq_cnt++;
            chk($sformatf("ctrl_cyc%0d", edge_n - start_edge + 1),
                32'(act_vec), 32'(exp_vec(edge_n - start_edge + 1)));
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ctl"}, 32'({busy, done, w_rd_en, rand_req}), 32'd0);
        chk({tag, "_ctl2"}, 32'({busy2, done2, w_rd_en2, rand_req2}), 32'd0);
        for (int c = 0; c < NC; c++) begin
            cnt_sel = 1'(c);
            #1;
            chk($sformatf("%s_cnt%0d", tag, c), 32'(cnt_out), 32'd0);
        end
        chk({tag, "_class"}, 32'(class_out), 32'd0);
    endtask

    task automatic run1(input bit noise);
        model_run(2 ** CW - 1, NI);
        do_reset();
        rq_cnt = 0;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        start_edge = edge_n;
        mon_on = 1'b1;
        for (int i = 1; i <= DONE_CYC + 1; i++) begin
            start = noise && (i == 10 || i == 30 || i == DONE_CYC - 1 || i == DONE_CYC);
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        mon_on = 1'b0;
        chk("rand_req_count", 32'(rq_cnt), 32'(NI * (NH + NC)));
        for (int c = 0; c < NC; c++) begin
            cnt_sel = 1'(c);
            #1;
            chk($sformatf("model_cnt%0d", c), 32'(cnt_out), 32'(exp_cnt[c]));
        end
        chk("model_class", 32'(class_out), 32'(exp_cls));
    endtask

    task automatic lit(input string tag, input int c0, input int c1, input int cls);
        chk({tag, "_pin_model0"}, 32'(exp_cnt[0]), 32'(c0));
        chk({tag, "_pin_model1"}, 32'(exp_cnt[1]), 32'(c1));
        cnt_sel = 1'b0;
        #1 chk({tag, "_cnt0"}, 32'(cnt_out), 32'(c0));
        cnt_sel = 1'b1;
        #1 chk({tag, "_cnt1"}, 32'(cnt_out), 32'(c1));
        chk({tag, "_class"}, 32'(class_out), 32'(cls));
    endtask

    task automatic fill_random();
        for (int r = 0; r < NV; r++) img[r] = 1'($urandom_range(1));
        for (int h = 0; h < NH; h++) begin
            hb[h] = int'($urandom_range(40)) - 20;
            for (int r = 0; r < NV; r++) hw[h][r] = int'($urandom_range(40)) - 20;
        end
        for (int c = 0; c < NC; c++) begin
            cb[c] = int'($urandom_range(40)) - 20;
            for (int r = 0; r < NH; r++) cw[c][r] = int'($urandom_range(40)) - 20;
        end
        for (int k = 0; k < 64; k++) rseq[k] = int'($urandom_range(60)) - 30;
    endtask

    task automatic set_all(input logic [3:0] im, input int hwv, input int hbv,
                           input int c0, input int c1, input int cbv,
                           input int rh, input int rc);
        for (int r = 0; r < NV; r++) img[r] = im[r];
        for (int h = 0; h < NH; h++) begin
            hb[h] = hbv;
            for (int r = 0; r < NV; r++) hw[h][r] = hwv;
        end
        for (int c = 0; c < NC; c++) begin
            cb[c] = cbv;
            for (int r = 0; r < NH; r++) cw[c][r] = (c == 0) ? c0 : c1;
        end
        for (int k = 0; k < 64; k++) rseq[k] = (k % (NH + NC) < NH) ? rh : rc;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int dcyc;
        do_reset();
        check_idle("reset");

        for (int r = 0; r < 6; r++) begin
            fill_random();
            run1(r == 3);
        end

        set_all(4'b1101, 10, 0, 5, -5, 0, 0, 0);
        run1(1'b0);
        lit("basic", 2, 0, 0);

        set_all(4'b1101, 10, 0, 5, 5, 0, 0, 0);
        run1(1'b0);
        lit("tie", 2, 2, 0);

        set_all(4'b1101, 10, 0, -5, 5, 0, 0, 0);
        run1(1'b0);
        lit("swap", 0, 2, 1);

        set_all(4'b0000, 10, 7, -5, -5, 1, 7, 0);
        run1(1'b0);
        lit("thresh_eq", 2, 2, 0);

        set_all(4'b1111, 10, 10, 5, 5, 5, 0, 0);
        model_run(1, 3);
        do_reset();
        start2 = 1'b1;
        @(posedge clock);
        #1 start2 = 1'b0;
        dcyc = -1;
        for (int i = 1; i <= 100; i++) begin
            if (done2 && dcyc < 0) dcyc = i;
            @(posedge clock);
            #1;
        end
        chk("sat_done_cycle", 32'(dcyc), 32'(3 * L + NC + 1));
        chk("sat_pin_model0", 32'(exp_cnt[0]), 32'd1);
        chk("sat_pin_model1", 32'(exp_cnt[1]), 32'd1);
        for (int c = 0; c < NC; c++) begin
            cnt_sel2 = 1'(c);
            #1 chk($sformatf("sat_cnt%0d", c), 32'(cnt_out2), 32'(exp_cnt[c]));
        end
        chk("sat_class", 32'(class_out2), 32'd0);

        fill_random();
        do_reset();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        start_edge = edge_n;
        mon_on = 1'b1;
        repeat (19) begin
            @(posedge clock);
            #1;
        end
        mon_on = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check_idle("midrst");
        run1(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rbm_infer_ctrl.md
# rbm_infer_ctrl

Synthesizable, parametrised RBM inference sequencer. Runs a two-layer RBM (visible→hidden, hidden→class) for `N_ITER` stochastic iterations and accumulates per-class spike counts, then reports the arg-max class. It sits between the weight/image memories and the host control logic. It replaces the behavioural bench sequencing with hardware that has configurable layer sizes, an integrated accumulator, saturating counters and a result arg-max.

## Interface
- `N_VIS`, 784: visible inputs per image.
- `N_HID`, 441: hidden neurons.
- `N_CLS`, 10: classes.
- `N_ITER`, 30: stochastic iterations per inference.
- `W_WIDTH`, 12: signed weight/bias width.
- `CNT_WIDTH`, 8: spike counter width.

Ports (reset is synchronous, active-high; clock is `clock`):
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `busy`  out  1  high from the cycle after start acceptance until done.
- `done`  out  1  one-cycle pulse when the result is valid.
- `w_rd_en`  out  1  weight read strobe.
- `w_layer`  out  1  0 = hidden weights, 1 = classifier weights.
- `w_bias`  out  1  high when a bias is addressed (`w_row` is don't-care).
- `w_row`  out  clog2(max(N_VIS,N_HID))  input index.
- `w_col`  out  clog2(max(N_HID,N_CLS))  neuron index.
- `w_data`  in  W_WIDTH  signed; valid one cycle after `w_rd_en`.
- `vis_addr`  out  clog2(N_VIS)  image bit address; issued with `w_row`.
- `vis_data`  in  1  image bit; valid one cycle after the address.
- `rand_in`  in  W_WIDTH  signed threshold, sign-extended.
- `rand_req`  out  1  pulse in each FIRE cycle; advances the external LFSR.
- `cnt_sel`  in  clog2(N_CLS)  class count select.
- `cnt_out`  out  CNT_WIDTH  combinational count for `cnt_sel`.
- `class_out`  out  clog2(N_CLS)  arg-max class; registered.

## Operation
- States: IDLE, HID_ACC, HID_FIRE, CLS_ACC, CLS_FIRE, ARGMAX, DONE.
- IDLE + `start`: clear all counts, iteration counter and `class_out`. Next state is HID_ACC with `w_col=0`.
- HID_ACC: issue `w_row` = 0..N_VIS-1, then one bias read, i.e. N_VIS+1 issue cycles.
- Accumulator: each returning word adds `w_data` if the paired input bit is 1, otherwise 0. Bias is always added. Reads are issued regardless of the input bit.
- HID_FIRE (1 cycle): final bias is added and the hidden bit is set to (acc_next > rand_in), a signed, strict comparison. The bit is stored in an internal N_HID-bit register. The accumulator is then cleared and the next neuron starts. After neuron N_HID-1, go to CLS_ACC.
- CLS_ACC / CLS_FIRE: same pattern, with N_HID inputs taken from the stored hidden bits. On fire, the class count increments and saturates at 2^CNT_WIDTH−1.
- After class N_CLS-1: if iterations < N_ITER, return to HID_ACC; otherwise go to ARGMAX.
- ARGMAX: one class per cycle for N_CLS cycles. Strictly greater replaces the current best, so ties keep the lowest index.
- DONE: `done`=1 for one cycle, `busy` drops in the same cycle, then IDLE.
- Accumulator width is W_WIDTH + clog2(max(N_VIS,N_HID)+2), signed, and cannot overflow.
- `start` while busy is ignored.
- `reset` at any time forces IDLE and zeroes counts, hidden bits, `class_out`, `busy`, `done`, `w_rd_en` and `rand_req`.

## Timing
- Per hidden neuron: N_VIS+2 cycles. Per class neuron: N_HID+2 cycles.
- Iteration length: L = N_HID·(N_VIS+2) + N_CLS·(N_HID+2).
- With `start` sampled at edge 0: the first HID_ACC cycle is cycle 1, ARGMAX occupies cycles N_ITER·L+1 through N_ITER·L+N_CLS, and `done` is high at cycle N_ITER·L+N_CLS+1.
- Memory latency is fixed at 1 cycle; no backpressure.
- `cnt_out` and `class_out` hold their values until the next accepted `start`.

## Structure
- `rbm_pkg` holds:
  - the state enum;
  - the layer-select constants (HID=0, CLS=1);
  - the `acc_width(W,N)` function.
- One sub-module, `rbm_neuron_acc`: accumulator, input gating, bias add and signed threshold compare. It is reused by both layers.
- The counters, hidden register file and arg-max stay in the top module.

## Test plan
Configuration for all scenarios: N_VIS=4, N_HID=3, N_CLS=2, N_ITER=2, W_WIDTH=8, CNT_WIDTH=8. This gives L=28 and `done` at cycle 59.

1. **Reset and latency.** Assert reset → all outputs 0. Pulse `start` → `busy`=1 at cycle 1; `done`=1 and `busy`=0 at cycle 59; `rand_req` count = 2·(3+2) = 10.
2. **Basic classification.** Image 1011, hidden weights +10, biases 0, `rand_in`=0 → all hidden bits 1. Class0 weights +5, class1 weights −5 → counts (2,0), `class_out`=0.
3. **Tie.** Equal classifier weights +5 → counts (2,2), `class_out`=0. Swap to class0 −5, class1 +5 → `class_out`=1.
4. **Threshold equality.** Image 0000, hidden bias 7, `rand_in`=7 → hidden bits all 0. Classifier bias 1, `rand_in`=0 → counts (2,2).
5. **Saturation.** CNT_WIDTH=1, N_ITER=3, always-fire weights → `cnt_out`=1 for both classes.
6. **Reset mid-run.** Reset at cycle 20 → IDLE, `busy`=0, counts 0. Re-`start` → full 59-cycle run, and `start` pulses issued during the run are ignored.
